// File: rtl/motoro3_step_sequencer.sv
// motoro3_step_sequencer
// Produces the 12-sub-step commutation frame (step index, per-step down
// counter and boundary strobes) that feeds motoro3_pwm_generator. Handles
// start, graceful stop at the end of a round, abort and round counting.
// All state advances on the falling edge of clk, like the PWM generator.
module motoro3_step_sequencer #(
  parameter int CNT_W   = 25,
  parameter int MIN_LEN = 4
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             start,
  input  logic             stop,
  input  logic             abort,
  input  logic [CNT_W-1:0] m3r_stepLen,
  input  logic [15:0]      m3r_roundMax,
  output logic [3:0]       sgStep,
  output logic [CNT_W-1:0] m3cnt,
  output logic             m3cntFirst2,
  output logic             m3cntFirst1,
  output logic             m3cntLast2,
  output logic             m3cntLast1,
  output logic             pwmActive1,
  output logic             pwmLastStep1,
  output logic [15:0]      roundCnt,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MIN_LEN_C = CNT_W'(MIN_LEN);
  localparam logic [3:0]       LAST_STEP = 4'd11;

  state_t           state_q, state_d;
  logic [3:0]       step_q, step_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [15:0]      round_q, round_d;
  logic             done_q, done_d;

  logic [CNT_W-1:0] len_eff;
  logic             active;
  logic             step_wrap;
  logic             round_end;
  logic             limit_hit;

  // Clamp the requested step length so the four strobes stay distinct
  always_comb begin
    len_eff = (m3r_stepLen < MIN_LEN_C) ? MIN_LEN_C : m3r_stepLen;
  end

  // Decode step boundaries and the round-limit condition from registered state
  always_comb begin
    active    = (state_q != IDLE);
    step_wrap = (cnt_q == '0);
    round_end = step_wrap && (step_q == LAST_STEP);
    limit_hit = (m3r_roundMax != 16'd0) &&
                (round_q == m3r_roundMax - 16'd1) &&
                (step_q == 4'd0) &&
                (cnt_q == len_q - CNT_W'(1));
  end

  // Next-state, counter reload and round bookkeeping
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    round_d = round_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = RUN;
          step_d  = 4'd0;
          cnt_d   = len_eff - CNT_W'(1);
          len_d   = len_eff;
          round_d = 16'd0;
        end
      end
      RUN, DRAIN: begin
        if (abort) begin
          state_d = IDLE;
          step_d  = 4'd0;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          if (step_wrap) begin
            cnt_d  = len_eff - CNT_W'(1);
            len_d  = len_eff;
            step_d = (step_q == LAST_STEP) ? 4'd0 : step_q + 4'd1;
            if (step_q == LAST_STEP) begin
              round_d = round_q + 16'd1;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
          if (round_end && ((state_q == DRAIN) || stop)) begin
            state_d = IDLE;
            step_d  = 4'd0;
            cnt_d   = '0;
            len_d   = len_q;
            done_d  = 1'b1;
          end else if ((state_q == RUN) && (stop || limit_hit)) begin
            state_d = DRAIN;
          end
        end
      end
      default: begin
        state_d = IDLE;
        step_d  = 4'd0;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers, falling-edge clocked with asynchronous active-low reset
  always_ff @(negedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q <= IDLE;
      step_q  <= 4'd0;
      cnt_q   <= '0;
      len_q   <= MIN_LEN_C;
      round_q <= 16'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      round_q <= round_d;
      done_q  <= done_d;
    end
  end

  // Output decode; strobes are suppressed whenever the frame is not running
  always_comb begin
    sgStep       = step_q;
    m3cnt        = cnt_q;
    roundCnt     = round_q;
    done         = done_q;
    pwmActive1   = active;
    pwmLastStep1 = (state_q == DRAIN) && (step_q == LAST_STEP);
    m3cntFirst2  = active && (cnt_q == len_q - CNT_W'(1));
    m3cntFirst1  = active && (cnt_q == len_q - CNT_W'(2));
    m3cntLast2   = active && (cnt_q == CNT_W'(1));
    m3cntLast1   = active && (cnt_q == '0);
  end

endmodule

// File: tb/tb_motoro3_step_sequencer.sv
// Directed testbench for motoro3_step_sequencer. Inputs change just after
// the rising edge and outputs are sampled at the rising edge, half a period
// away from the falling edge that updates the DUT.
module tb_motoro3_step_sequencer;

  localparam int CNT_W = 25;

  logic             clk;
  logic             nRst;
  logic             start;
  logic             stop;
  logic             abort;
  logic [CNT_W-1:0] m3r_stepLen;
  logic [15:0]      m3r_roundMax;
  logic [3:0]       sgStep;
  logic [CNT_W-1:0] m3cnt;
  logic             m3cntFirst2;
  logic             m3cntFirst1;
  logic             m3cntLast2;
  logic             m3cntLast1;
  logic             pwmActive1;
  logic             pwmLastStep1;
  logic [15:0]      roundCnt;
  logic             done;

  int compared;
  int mismatched;
  int doneCount;

  motoro3_step_sequencer #(.CNT_W(CNT_W), .MIN_LEN(4)) dut (
    .clk          (clk),
    .nRst         (nRst),
    .start        (start),
    .stop         (stop),
    .abort        (abort),
    .m3r_stepLen  (m3r_stepLen),
    .m3r_roundMax (m3r_roundMax),
    .sgStep       (sgStep),
    .m3cnt        (m3cnt),
    .m3cntFirst2  (m3cntFirst2),
    .m3cntFirst1  (m3cntFirst1),
    .m3cntLast2   (m3cntLast2),
    .m3cntLast1   (m3cntLast1),
    .pwmActive1   (pwmActive1),
    .pwmLastStep1 (pwmLastStep1),
    .roundCnt     (roundCnt),
    .done         (done)
  );

  // 10 MHz clock
  initial begin
    clk = 1'b1;
    forever #50 clk = ~clk;
  end

  // Drive the three request pulses for the coming falling edge
  task automatic applyStimulus(input logic s, input logic p, input logic a);
    start = s;
    stop  = p;
    abort = a;
  endtask

  // One comparison: count it, and report observed/expected when it differs
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Advance n rising edges
  task automatic advance(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
  endtask

  // Strobe pattern expected for a given counter value and step length
  task automatic checkStrobes(input string tag, input int cnt, input int len);
    checkOutput({tag, ".first2"}, {31'd0, m3cntFirst2}, {31'd0, cnt == len - 1});
    checkOutput({tag, ".first1"}, {31'd0, m3cntFirst1}, {31'd0, cnt == len - 2});
    checkOutput({tag, ".last2"},  {31'd0, m3cntLast2},  {31'd0, cnt == 1});
    checkOutput({tag, ".last1"},  {31'd0, m3cntLast1},  {31'd0, cnt == 0});
  endtask

  // Everything idle-quiet
  task automatic checkIdle(input string tag, input logic expDone);
    checkOutput({tag, ".active"}, {31'd0, pwmActive1}, 32'd0);
    checkOutput({tag, ".step"},   {28'd0, sgStep}, 32'd0);
    checkOutput({tag, ".cnt"},    {7'd0, m3cnt}, 32'd0);
    checkOutput({tag, ".strobes"},
                {28'd0, m3cntFirst2, m3cntFirst1, m3cntLast2, m3cntLast1}, 32'd0);
    checkOutput({tag, ".laststep"}, {31'd0, pwmLastStep1}, 32'd0);
    checkOutput({tag, ".done"},   {31'd0, done}, {31'd0, expDone});
  endtask

  // Directed sequence
  initial begin
    compared     = 0;
    mismatched   = 0;
    nRst         = 1'b0;
    m3r_stepLen  = 25'd10;
    m3r_roundMax = 16'd1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    advance(3);
    checkIdle("reset", 1'b0);
    checkOutput("reset.round", {16'd0, roundCnt}, 32'd0);
    nRst = 1'b1;
    advance(2);
    checkIdle("idle", 1'b0);

    // Basic run: 12 steps of 10 clocks, single round, then done
    applyStimulus(1'b1, 1'b0, 1'b0);
    @(posedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 120; k++) begin
      checkOutput("basic.active", {31'd0, pwmActive1}, 32'd1);
      checkOutput("basic.step", {28'd0, sgStep}, k / 10);
      checkOutput("basic.cnt", {7'd0, m3cnt}, 9 - (k % 10));
      checkStrobes("basic", 9 - (k % 10), 10);
      checkOutput("basic.laststep", {31'd0, pwmLastStep1}, {31'd0, k >= 110});
      checkOutput("basic.done", {31'd0, done}, 32'd0);
      checkOutput("basic.round", {16'd0, roundCnt}, 32'd0);
      @(posedge clk);
    end
    checkIdle("basic.end", 1'b1);
    checkOutput("basic.end.round", {16'd0, roundCnt}, 32'd1);
    @(posedge clk);
    checkOutput("basic.done.fall", {31'd0, done}, 32'd0);

    // Clamp: stepLen 2 runs as 4-clock steps with four distinct strobes
    m3r_stepLen  = 25'd2;
    m3r_roundMax = 16'd0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    @(posedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      checkOutput("clamp.step", {28'd0, sgStep}, k / 4);
      checkOutput("clamp.cnt", {7'd0, m3cnt}, 3 - (k % 4));
      checkStrobes("clamp", 3 - (k % 4), 4);
      @(posedge clk);
    end
    applyStimulus(1'b0, 1'b0, 1'b1);
    @(posedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkIdle("clamp.abort", 1'b1);
    @(posedge clk);

    // Mid-step length change: step 3 keeps 10 clocks, step 4 gets 20
    m3r_stepLen = 25'd10;
    applyStimulus(1'b1, 1'b0, 1'b0);
    @(posedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 34; k++) begin
      checkOutput("len.pre.step", {28'd0, sgStep}, k / 10);
      checkOutput("len.pre.cnt", {7'd0, m3cnt}, 9 - (k % 10));
      @(posedge clk);
    end
    m3r_stepLen = 25'd20;
    for (int j = 0; j < 6; j++) begin
      checkOutput("len.s3.step", {28'd0, sgStep}, 32'd3);
      checkOutput("len.s3.cnt", {7'd0, m3cnt}, 5 - j);
      checkStrobes("len.s3", 5 - j, 10);
      @(posedge clk);
    end
    for (int j = 0; j < 20; j++) begin
      checkOutput("len.s4.step", {28'd0, sgStep}, 32'd4);
      checkOutput("len.s4.cnt", {7'd0, m3cnt}, 19 - j);
      checkStrobes("len.s4", 19 - j, 20);
      @(posedge clk);
    end
    checkOutput("len.s5.step", {28'd0, sgStep}, 32'd5);
    applyStimulus(1'b0, 1'b0, 1'b1);
    @(posedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkIdle("len.abort", 1'b1);
    @(posedge clk);

    // Graceful stop: endless run, stop in step 4 of round 2
    m3r_stepLen  = 25'd4;
    m3r_roundMax = 16'd0;
    doneCount    = 0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    @(posedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0);
    advance(112);
    checkOutput("stop.round", {16'd0, roundCnt}, 32'd2);
    checkOutput("stop.step", {28'd0, sgStep}, 32'd4);
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int k = 112; k < 150; k++) begin
      if (done) doneCount++;
      checkOutput("stop.active", {31'd0, pwmActive1}, {31'd0, k < 144});
      checkOutput("stop.laststep", {31'd0, pwmLastStep1},
                  {31'd0, (k >= 140) && (k < 144)});
      if (k == 144) begin
        checkOutput("stop.end.round", {16'd0, roundCnt}, 32'd3);
        checkOutput("stop.end.done", {31'd0, done}, 32'd1);
      end
      @(posedge clk);
      applyStimulus(1'b0, 1'b0, 1'b0);
    end
    checkOutput("stop.donecount", doneCount, 32'd1);

    // Abort together with stop in step 6
    applyStimulus(1'b1, 1'b0, 1'b0);
    @(posedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0);
    advance(24);
    checkOutput("abort.step", {28'd0, sgStep}, 32'd6);
    applyStimulus(1'b0, 1'b1, 1'b1);
    @(posedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkIdle("abort", 1'b1);
    @(posedge clk);
    checkOutput("abort.done.fall", {31'd0, done}, 32'd0);

    // Start together with abort in IDLE stays idle
    applyStimulus(1'b1, 1'b0, 1'b1);
    @(posedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkIdle("startabort", 1'b0);

    // Asynchronous reset mid-run at step 7, then a clean restart
    applyStimulus(1'b1, 1'b0, 1'b0);
    @(posedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0);
    advance(28);
    checkOutput("rst.step", {28'd0, sgStep}, 32'd7);
    nRst = 1'b0;
    #1;
    checkIdle("rst.async", 1'b0);
    checkOutput("rst.round", {16'd0, roundCnt}, 32'd0);
    @(posedge clk);
    nRst = 1'b1;
    @(posedge clk);
    checkIdle("rst.release", 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    @(posedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("rst.restart.active", {31'd0, pwmActive1}, 32'd1);
    checkOutput("rst.restart.cnt", {7'd0, m3cnt}, 32'd3);
    checkStrobes("rst.restart", 3, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/motoro3_step_sequencer.md
# motoro3_step_sequencer

- Generates the 12-sub-step three-phase commutation frame that drives `motoro3_pwm_generator`:
  - the step index `sgStep`;
  - the per-step down-counter `m3cnt`;
  - the step-boundary strobes `m3cntFirst2/1` and `m3cntLast2/1`;
  - `pwmActive1` and `pwmLastStep1`.
- Sits directly upstream of the PWM generator, one instance per motor.
- Handles start, graceful stop, abort and round counting.
- Step length is reloaded only at step boundaries, so register writes never tear a step.

## Interface

Parameters:
- `CNT_W`, 25: width of `m3cnt` and `m3r_stepLen`.
- `MIN_LEN`, 4: minimum effective step length in clocks. The four boundary strobes must be distinct.

Ports:
- `clk`, input, 1: 10 MHz. All registers update on the falling edge, matching the PWM generator.
- `nRst`, input, 1: reset, asynchronous, active-low.
- `start`, input, 1: one-cycle request to begin running. Honoured only in IDLE.
- `stop`, input, 1: one-cycle request to finish the current round, then go idle.
- `abort`, input, 1: one-cycle request for immediate return to IDLE.
- `m3r_stepLen`, input, CNT_W: clocks per sub-step. Values below MIN_LEN are clamped to MIN_LEN.
- `m3r_roundMax`, input, 16: number of rounds to run. 0 means run forever.
- `sgStep`, output, 4: current sub-step, 0..11.
- `m3cnt`, output, CNT_W: remaining clocks in the current step, counting down to 0.
- `m3cntFirst2`, output, 1: first cycle of a step.
- `m3cntFirst1`, output, 1: second cycle of a step.
- `m3cntLast2`, output, 1: second-to-last cycle of a step.
- `m3cntLast1`, output, 1: last cycle of a step.
- `pwmActive1`, output, 1: high in RUN and DRAIN.
- `pwmLastStep1`, output, 1: high during step 11 of the final round.
- `roundCnt`, output, 16: number of completed rounds.
- `done`, output, 1: one-cycle pulse on entry to IDLE. Does not pulse on reset.

## Operation

- States: IDLE, RUN, DRAIN.
- A "round" is sub-steps 0 → 11.
- Effective length:
  - `lenEff = max(m3r_stepLen, MIN_LEN)`.
  - `lenEff` is sampled only when `m3cnt` is loaded (at start and at every step wrap).
- IDLE:
  - `sgStep = 0`, `m3cnt = 0`, all strobes low, `pwmActive1 = 0`.
  - On `start` (and no `abort`): go to RUN, `sgStep ← 0`, `m3cnt ← lenEff − 1`, `roundCnt ← 0`.
- RUN / DRAIN counter behaviour:
  - Each cycle, `m3cnt ← m3cnt − 1`.
  - When `m3cnt == 0`: `m3cnt ← lenEff − 1` and `sgStep ← sgStep + 1`, wrapping 11 → 0.
  - On the 11 → 0 wrap: `roundCnt ← roundCnt + 1`, modulo 2^16.
- Strobes are combinational decodes of the registered `m3cnt`, gated by `pwmActive1`:
  - `First2` ⇔ `m3cnt == lenLatched − 1`.
  - `First1` ⇔ `m3cnt == lenLatched − 2`.
  - `Last2` ⇔ `m3cnt == 1`.
  - `Last1` ⇔ `m3cnt == 0`.
  - `lenLatched` is the `lenEff` captured at the last load.
- Transition RUN → DRAIN when either:
  - `stop` is asserted; or
  - `m3r_roundMax ≠ 0` and `roundCnt == m3r_roundMax − 1` at the start of step 0.
- DRAIN:
  - `pwmLastStep1 = (sgStep == 11)`.
  - On the `Last1` cycle of step 11: go to IDLE, pulse `done`, `roundCnt` increments.
- `abort` in RUN or DRAIN: go to IDLE on the next edge and pulse `done`. `sgStep`, `m3cnt` and the strobes are cleared.
- Priority, highest first: `abort` > `stop` > round limit > `start`.
  - `start` in RUN or DRAIN is ignored.
  - `stop` in DRAIN is ignored.
  - `start` together with `abort` in IDLE: stay in IDLE.
- `m3r_stepLen` changed mid-step: takes effect at the next step's load only.
- Reset values: all outputs 0. `lenLatched = MIN_LEN`.

## Timing

- Start latency is 1 clock: `start` sampled at edge N; at edge N+1 the block shows `pwmActive1 = 1`, `sgStep = 0`, `m3cnt = lenEff − 1`, `First2 = 1`.
- Each step lasts exactly `lenLatched` clocks; a round lasts `12 × lenLatched` clocks.
- Strobe order within a step: `First2`, `First1`, …, `Last2`, `Last1`. Each is high for exactly one cycle, and no two are high together, because `lenLatched ≥ 4`.
- Stop latency: the block returns to IDLE on the edge after the `Last1` of step 11 in the current round.
  - If `stop` arrives during the `Last1` cycle of step 11, that round ends the run.
- Abort latency is 1 clock.
- `pwmLastStep1` rises at the `First2` edge of step 11 and falls with `pwmActive1`.

## Test plan

- **Basic run.**
  - Stimulus: `stepLen = 10`, `roundMax = 1`, `start`.
  - Required: `sgStep` steps 0..11 with 10 clocks per step; strobes at `m3cnt = 9/8/1/0`; `pwmLastStep1` high for the 10 clocks of step 11; `done` 120 clocks after `pwmActive1` rises; `roundCnt = 1`.
- **Clamp.**
  - Stimulus: `stepLen = 2`.
  - Required: steps last 4 clocks; the four strobes fall on four distinct cycles.
- **Mid-step length change.**
  - Stimulus: `stepLen` changed 10 → 20 at `m3cnt = 5` of step 3.
  - Required: step 3 still lasts 10 clocks; step 4 lasts 20.
- **Graceful stop.**
  - Stimulus: `roundMax = 0`; `stop` pulsed in step 4 of round 2.
  - Required: the block finishes step 11 of that round, then goes to IDLE; `roundCnt = 3`; `done` pulses once.
- **Abort and simultaneity.**
  - Stimulus A: `abort` together with `stop` in step 6.
  - Required A: IDLE on the next edge, all strobes 0, `done` pulses.
  - Stimulus B: `start` together with `abort` in IDLE.
  - Required B: stays in IDLE.
- **Reset.**
  - Stimulus: `nRst` asserted mid-run at step 7.
  - Required: immediately all outputs 0 and IDLE; `done` stays low; a `start` after release runs normally.
